// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan controller.
package seg_pkg;

  localparam int NUM_DIGITS_DEFAULT = 4;
  localparam int TICK_DIV_DEFAULT   = 50000;
  localparam int BLANK_CYCLES       = 2;

  // Width of a counter or index that must hold values 0..n-1 (at least one bit).
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running slot prescaler: counts 0..TICK_DIV-1, ticks on the last count and
// optionally flags the leading blanking window of each slot.
module scan_prescaler
  import seg_pkg::*;
#(
  parameter int TICK_DIV     = TICK_DIV_DEFAULT,
  parameter bit BLANK_EN     = 1'b0,
  parameter int BLANK_LENGTH = BLANK_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick,
  output logic o_blank
);

  localparam int CW = idx_width(TICK_DIV);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == CW'(TICK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_tick  = w_last;
  assign o_blank = BLANK_EN && (r_count < CW'(BLANK_LENGTH));

endmodule

// File: rtl/seg_scan_ctrl.sv
// Common-anode display scan controller with tear-free frame-synchronous updates.
// Define SEG_SCAN_GHOST_BLANK_EN to blank all digits at the start of every slot.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT,
  parameter int TICK_DIV   = TICK_DIV_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  output logic [3:0]              hex,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    pending,
  output logic                    frame_tick
);

  localparam int IW = idx_width(NUM_DIGITS);
`ifdef SEG_SCAN_GHOST_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic                    w_slot_end;
  logic                    w_blank;
  logic                    w_wrap;
  logic [4*NUM_DIGITS-1:0] w_shifted;
  logic [NUM_DIGITS-1:0]   w_onehot;

  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_display;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic                    r_pending;
  logic                    r_frame_tick;

  scan_prescaler #(
    .TICK_DIV     (TICK_DIV),
    .BLANK_EN     (BLANK_EN),
    .BLANK_LENGTH (BLANK_CYCLES)
  ) u_prescaler (
    .i_clk   (clk),
    .i_rst   (rst),
    .o_tick  (w_slot_end),
    .o_blank (w_blank)
  );

  assign w_wrap = w_slot_end && (r_idx == IW'(NUM_DIGITS - 1));

  // A load on the wrap edge bypasses the shadow so it is shown without a frame of delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_display    <= '0;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_idx <= w_wrap ? '0 : r_idx + IW'(1);
      end
      r_frame_tick <= w_wrap;
      if (load) begin
        r_shadow <= data_in;
      end
      if (w_wrap) begin
        r_display <= load ? data_in : r_shadow;
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign w_shifted = r_display >> {r_idx, 2'b00};
  assign w_onehot  = NUM_DIGITS'(1) << r_idx;

  always_comb begin
    hex      = w_shifted[3:0];
    digit_en = ~w_onehot;
    if (w_blank) begin
      digit_en = '1;
    end
  end

  assign pending    = r_pending;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NUM_DIGITS=4, TICK_DIV=4) against a
// time-based reference model; honours SEG_SCAN_GHOST_BLANK_EN when defined.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int TK = 4;
`ifdef SEG_SCAN_GHOST_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   dataIn = '0;
  logic [3:0]    hex;
  logic [3:0]    digitEn;
  logic          pending;
  logic          frameTick;

  int nChecks = 0;
  int nFail   = 0;

  // Reference model: time since reset fully determines digit index and slot phase.
  int          mT = 0;
  logic [15:0] mDisp = '0;
  logic [15:0] mShadow = '0;
  logic        mPend = 1'b0;
  logic        mFt = 1'b0;

  logic [3:0]  capHex [4];
  logic        capPendSeen;

  typedef struct {
    logic        r;
    logic        l;
    logic [15:0] d;
    logic [3:0]  hex;
    logic [3:0]  den;
    logic        blank;
    logic        pend;
    logic        ft;
  } vec_t;

  vec_t vecs [7];

  seg_scan_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TK)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (dataIn),
    .hex        (hex),
    .digit_en   (digitEn),
    .pending    (pending),
    .frame_tick (frameTick)
  );

  always #5 clk = ~clk;

  function automatic int curIdx();
    return (mT / TK) % ND;
  endfunction

  function automatic int curPre();
    return mT % TK;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, mT);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic l, input logic [15:0] d);
    logic        wrap;
    logic [15:0] tmp;
    logic [3:0]  eHex;
    logic [3:0]  eDen;
    int          i;
    rst    = r;
    load   = l;
    dataIn = d;
    @(posedge clk);
    if (r) begin
      mT = 0; mDisp = '0; mShadow = '0; mPend = 1'b0; mFt = 1'b0;
    end else begin
      wrap = (curPre() == TK - 1) && (curIdx() == ND - 1);
      if (l) mShadow = d;
      if (wrap) begin
        mDisp = mShadow;
        mPend = 1'b0;
      end else if (l) begin
        mPend = 1'b1;
      end
      mFt = wrap;
      mT++;
    end
    #1;
    i    = curIdx();
    tmp  = mDisp >> (4 * i);
    eHex = tmp[3:0];
    eDen = ~(4'b0001 << i);
    if (BLANK_ON && curPre() < 2) eDen = 4'hF;
    checkOutput("model hex", {28'd0, hex}, {28'd0, eHex});
    checkOutput("model digit_en", {28'd0, digitEn}, {28'd0, eDen});
    checkOutput("model pending", {31'd0, pending}, {31'd0, mPend});
    checkOutput("model frame_tick", {31'd0, frameTick}, {31'd0, mFt});
  endtask

  task automatic waitPhase(input int idx, input int pre);
    int n = 0;
    while (!(curIdx() == idx && curPre() == pre) && n < 64) begin
      applyStimulus(1'b0, 1'b0, 16'h0);
      n++;
    end
    if (n >= 64) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL phase timeout: wanted idx %0d pre %0d, got idx %0d pre %0d", idx, pre, curIdx(), curPre());
    end
  endtask

  // Assumes the current state is the first cycle of a frame.
  task automatic captureFrame();
    capPendSeen = 1'b0;
    for (int s = 0; s < ND; s++) begin
      capHex[s] = hex;
      if (pending) capPendSeen = 1'b1;
      for (int c = 0; c < TK; c++) begin
        applyStimulus(1'b0, 1'b0, 16'h0);
        if (pending && !(s == ND - 1 && c == TK - 1)) capPendSeen = 1'b1;
      end
    end
  endtask

  task automatic checkFrame(input string name, input logic [15:0] expVal);
    logic [15:0] v;
    v = expVal;
    for (int s = 0; s < ND; s++) begin
      checkOutput($sformatf("%s digit%0d", name, s), {28'd0, capHex[s]}, {28'd0, v[3:0]});
      v = v >> 4;
    end
  endtask

  initial begin
    logic [3:0] eDen;
    vecs[0] = '{r:1, l:0, d:16'h0,    hex:4'h0, den:4'hE, blank:1, pend:0, ft:0};
    vecs[1] = '{r:0, l:0, d:16'h0,    hex:4'h0, den:4'hE, blank:1, pend:0, ft:0};
    vecs[2] = '{r:0, l:0, d:16'h0,    hex:4'h0, den:4'hE, blank:0, pend:0, ft:0};
    vecs[3] = '{r:0, l:0, d:16'h0,    hex:4'h0, den:4'hE, blank:0, pend:0, ft:0};
    vecs[4] = '{r:0, l:0, d:16'h0,    hex:4'h0, den:4'hD, blank:1, pend:0, ft:0};
    vecs[5] = '{r:0, l:1, d:16'h1234, hex:4'h0, den:4'hD, blank:1, pend:1, ft:0};
    vecs[6] = '{r:0, l:0, d:16'h0,    hex:4'h0, den:4'hD, blank:0, pend:1, ft:0};

    // Reset, free run into slot 1, then load 0x1234 while idx==1.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(vecs[k].r, vecs[k].l, vecs[k].d);
      eDen = (BLANK_ON && vecs[k].blank) ? 4'hF : vecs[k].den;
      checkOutput($sformatf("vec%0d hex", k), {28'd0, hex}, {28'd0, vecs[k].hex});
      checkOutput($sformatf("vec%0d digit_en", k), {28'd0, digitEn}, {28'd0, eDen});
      checkOutput($sformatf("vec%0d pending", k), {31'd0, pending}, {31'd0, vecs[k].pend});
      checkOutput($sformatf("vec%0d frame_tick", k), {31'd0, frameTick}, {31'd0, vecs[k].ft});
    end

    // Captured data appears only after the wrap.
    waitPhase(0, 0);
    checkOutput("wrap1 frame_tick", {31'd0, frameTick}, 32'd1);
    checkOutput("wrap1 pending", {31'd0, pending}, 32'd0);
    captureFrame();
    checkFrame("load1234", 16'h1234);

    // Last write wins inside a frame.
    applyStimulus(1'b0, 1'b1, 16'hAAAA);
    repeat (3) applyStimulus(1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b1, 16'h5555);
    waitPhase(0, 0);
    captureFrame();
    checkFrame("lastwins", 16'h5555);

    // Load on the wrap edge goes straight to the display.
    waitPhase(3, 3);
    applyStimulus(1'b0, 1'b1, 16'h9876);
    checkOutput("bypass frame_tick", {31'd0, frameTick}, 32'd1);
    captureFrame();
    checkFrame("bypass9876", 16'h9876);
    checkOutput("bypass pending never", {31'd0, capPendSeen}, 32'd0);

    // Reset mid-frame with pending data, coincident with a load.
    applyStimulus(1'b0, 1'b1, 16'h4321);
    waitPhase(2, 1);
    checkOutput("pre-rst pending", {31'd0, pending}, 32'd1);
    applyStimulus(1'b1, 1'b1, 16'hFFFF);
    checkOutput("rst hex", {28'd0, hex}, 32'd0);
    checkOutput("rst pending", {31'd0, pending}, 32'd0);
    checkOutput("rst digit_en", {28'd0, digitEn}, BLANK_ON ? 32'hF : 32'hE);
    waitPhase(0, 0);
    captureFrame();
    checkFrame("after-rst", 16'h0000);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 79) == 0), ($urandom_range(0, 5) == 0), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
